// File: rtl/com_bus_arbiter.sv
// Round-robin arbiter for the shared common bus: single owner, one dead turnaround
// cycle between owners, and an optional cap on how long one owner may hold the bus.
module com_bus_arbiter #(
    parameter int NUM_REQ     = 8,
    parameter int ID_WIDTH    = 3,
    parameter int MAX_TENURE  = 64,
    parameter int TIMER_WIDTH = 7
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_REQ-1:0]  Com_Bus_Req,
    output logic [NUM_REQ-1:0]  Com_Bus_Gnt,
    output logic                Bus_Busy,
    output logic [ID_WIDTH-1:0] Gnt_Id,
    output logic                Tenure_Expired
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_GRANT   = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    localparam logic [ID_WIDTH-1:0]    LAST_ID      = ID_WIDTH'(NUM_REQ - 1);
    localparam logic [ID_WIDTH:0]      NUM_REQ_W    = (ID_WIDTH + 1)'(NUM_REQ);
    localparam logic [TIMER_WIDTH-1:0] TENURE_LIMIT = TIMER_WIDTH'(MAX_TENURE);
    localparam logic [TIMER_WIDTH-1:0] CNT_ONE      = TIMER_WIDTH'(1);

    logic [1:0]             state_r, state_s;
    logic [ID_WIDTH-1:0]    ptr_r, ptr_s;
    logic [TIMER_WIDTH-1:0] cnt_r, cnt_s;
    logic [NUM_REQ-1:0]     gnt_r, gnt_s;
    logic                   busy_r, busy_s;
    logic [ID_WIDTH-1:0]    id_r, id_s;
    logic                   exp_r, exp_s;

    logic [2*NUM_REQ-1:0]   req_dbl_s;
    logic [NUM_REQ-1:0]     req_rot_s;
    logic [ID_WIDTH-1:0]    win_off_s;
    logic [ID_WIDTH:0]      win_sum_s;
    logic [ID_WIDTH-1:0]    win_id_s;
    logic                   win_found_s;
    logic                   next_ptr_wrap_s;
    logic [ID_WIDTH-1:0]    next_ptr_s;

    // Rotate requests so that ptr sits at bit 0, then take the first set bit.
    always_comb begin
        req_dbl_s   = {Com_Bus_Req, Com_Bus_Req};
        req_rot_s   = NUM_REQ'(req_dbl_s >> ptr_r);
        win_found_s = 1'b0;
        win_off_s   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            win_off_s   = (!win_found_s && req_rot_s[i]) ? ID_WIDTH'(i) : win_off_s;
            win_found_s = win_found_s | req_rot_s[i];
        end
        win_sum_s = {1'b0, ptr_r} + {1'b0, win_off_s};
        if (win_sum_s >= NUM_REQ_W) begin
            win_id_s = ID_WIDTH'(win_sum_s - NUM_REQ_W);
        end else begin
            win_id_s = ID_WIDTH'(win_sum_s);
        end
    end

    // Priority moves to the requester just after the releasing owner.
    always_comb begin
        next_ptr_wrap_s = (id_r == LAST_ID);
        if (next_ptr_wrap_s) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = id_r + ID_WIDTH'(1);
        end
    end

    // Next-state logic for ownership, turnaround and tenure limiting.
    always_comb begin
        state_s = state_r;
        ptr_s   = ptr_r;
        cnt_s   = cnt_r;
        gnt_s   = gnt_r;
        id_s    = id_r;
        exp_s   = 1'b0;
        case (state_r)
            ST_IDLE, ST_RELEASE: begin
                if (win_found_s) begin
                    state_s = ST_GRANT;
                    gnt_s   = NUM_REQ'(1) << win_id_s;
                    id_s    = win_id_s;
                    cnt_s   = CNT_ONE;
                end else begin
                    state_s = ST_IDLE;
                    gnt_s   = '0;
                end
            end
            ST_GRANT: begin
                if (!Com_Bus_Req[id_r]) begin
                    state_s = ST_RELEASE;
                    gnt_s   = '0;
                    ptr_s   = next_ptr_s;
                end else if ((MAX_TENURE != 0) && (cnt_r == TENURE_LIMIT)) begin
                    state_s = ST_RELEASE;
                    gnt_s   = '0;
                    ptr_s   = next_ptr_s;
                    exp_s   = 1'b1;
                end else begin
                    // Saturate so a disabled limit never wraps the counter.
                    cnt_s = (cnt_r == '1) ? cnt_r : cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                gnt_s   = '0;
            end
        endcase
        busy_s = |gnt_s;
    end

    // State and registered outputs; reset drops any grant without a release cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            ptr_r   <= '0;
            cnt_r   <= '0;
            gnt_r   <= '0;
            busy_r  <= 1'b0;
            id_r    <= '0;
            exp_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            ptr_r   <= ptr_s;
            cnt_r   <= cnt_s;
            gnt_r   <= gnt_s;
            busy_r  <= busy_s;
            id_r    <= id_s;
            exp_r   <= exp_s;
        end
    end

    assign Com_Bus_Gnt    = gnt_r;
    assign Bus_Busy       = busy_r;
    assign Gnt_Id         = id_r;
    assign Tenure_Expired = exp_r;

endmodule

// File: tb/tb_com_bus_arbiter.sv
// Directed bench for com_bus_arbiter (tenure limit set to 4 cycles).
module tb_com_bus_arbiter;

    logic       clk;
    logic       reset_n;
    logic [7:0] req;
    logic [7:0] gnt;
    logic       busy;
    logic [2:0] gnt_id;
    logic       expired;

    int tests_run;
    int tests_failed;

    com_bus_arbiter #(
        .NUM_REQ    (8),
        .ID_WIDTH   (3),
        .MAX_TENURE (4),
        .TIMER_WIDTH(7)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .Com_Bus_Req   (req),
        .Com_Bus_Gnt   (gnt),
        .Bus_Busy      (busy),
        .Gnt_Id        (gnt_id),
        .Tenure_Expired(expired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req     = 8'h00;
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        req     = 8'h00;
        reset_n = 1'b0;
        tick();
        tests_run++;
        if (gnt !== 8'h00 || busy !== 1'b0 || gnt_id !== 3'd0 || expired !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: gnt=%h busy=%b id=%0d exp=%b expected 00 0 0 0", gnt, busy, gnt_id, expired);
        end
        reset_n = 1'b1;
        tick();
        tests_run++;
        if (gnt !== 8'h00 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_after_reset: gnt=%h busy=%b expected 00 0", gnt, busy);
        end
    endtask

    task automatic test_basic();
        do_reset();
        req = 8'h04;
        for (int c = 0; c < 3; c++) begin
            tick();
            tests_run++;
            if (gnt !== 8'h04 || gnt_id !== 3'd2 || busy !== 1'b1) begin
                tests_failed++;
                $display("FAIL basic_grant c%0d: gnt=%h id=%0d busy=%b expected 04 2 1", c, gnt, gnt_id, busy);
            end
        end
        req = 8'h00;
        tick();
        tests_run++;
        if (gnt !== 8'h00 || busy !== 1'b0 || expired !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_release: gnt=%h busy=%b exp=%b expected 00 0 0", gnt, busy, expired);
        end
        tick();
        tests_run++;
        if (gnt !== 8'h00 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_idle: gnt=%h busy=%b expected 00 0", gnt, busy);
        end
        // Idle-bus latency is one cycle; ptr is now 3 so 3 beats 1.
        req = 8'h0A;
        tick();
        tests_run++;
        if (gnt !== 8'h08 || gnt_id !== 3'd3) begin
            tests_failed++;
            $display("FAIL basic_ptr_after_release: gnt=%h id=%0d expected 08 3", gnt, gnt_id);
        end
        req = 8'h00;
        tick();
        tick();
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_gnt;
        do_reset();
        req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            exp_gnt = 8'h01 << (k % 8);
            for (int c = 0; c < 3; c++) begin
                tick();
                tests_run++;
                if (gnt !== exp_gnt || gnt_id !== 3'(k % 8) || busy !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL rr_grant k%0d c%0d: gnt=%h id=%0d busy=%b expected %h %0d 1", k, c, gnt, gnt_id, busy, exp_gnt, k % 8);
                end
            end
            req = 8'hFF & ~exp_gnt;
            tick();
            tests_run++;
            if (gnt !== 8'h00 || busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL rr_turnaround k%0d: gnt=%h busy=%b expected 00 0", k, gnt, busy);
            end
            req = 8'hFF;
        end
        req = 8'h00;
        tick();
        tick();
        tick();
    endtask

    task automatic test_wrap();
        do_reset();
        req = 8'h80;
        tick();
        tests_run++;
        if (gnt !== 8'h80 || gnt_id !== 3'd7) begin
            tests_failed++;
            $display("FAIL wrap_grant7: gnt=%h id=%0d expected 80 7", gnt, gnt_id);
        end
        req = 8'h81;
        tick();
        tests_run++;
        if (gnt !== 8'h80) begin
            tests_failed++;
            $display("FAIL wrap_no_preempt: gnt=%h expected 80", gnt);
        end
        req = 8'h01;
        tick();
        tests_run++;
        if (gnt !== 8'h00 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL wrap_release: gnt=%h busy=%b expected 00 0", gnt, busy);
        end
        tick();
        tests_run++;
        if (gnt !== 8'h01 || gnt_id !== 3'd0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL wrap_grant0: gnt=%h id=%0d busy=%b expected 01 0 1", gnt, gnt_id, busy);
        end
        req = 8'h00;
        tick();
        tick();
    endtask

    task automatic test_tenure();
        do_reset();
        req = 8'h20;
        tick();
        req = 8'h22;
        tests_run++;
        if (gnt !== 8'h20 || expired !== 1'b0) begin
            tests_failed++;
            $display("FAIL tenure_grant5 c0: gnt=%h exp=%b expected 20 0", gnt, expired);
        end
        for (int c = 1; c < 4; c++) begin
            tick();
            tests_run++;
            if (gnt !== 8'h20 || expired !== 1'b0) begin
                tests_failed++;
                $display("FAIL tenure_grant5 c%0d: gnt=%h exp=%b expected 20 0", c, gnt, expired);
            end
        end
        tick();
        tests_run++;
        if (gnt !== 8'h00 || expired !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL tenure_forced: gnt=%h exp=%b busy=%b expected 00 1 0", gnt, expired, busy);
        end
        tick();
        tests_run++;
        if (gnt !== 8'h02 || gnt_id !== 3'd1 || expired !== 1'b0) begin
            tests_failed++;
            $display("FAIL tenure_grant1: gnt=%h id=%0d exp=%b expected 02 1 0", gnt, gnt_id, expired);
        end
        tick();
        tests_run++;
        if (gnt !== 8'h02) begin
            tests_failed++;
            $display("FAIL tenure_hold1: gnt=%h expected 02", gnt);
        end
        req = 8'h20;
        tick();
        tests_run++;
        if (gnt !== 8'h00 || expired !== 1'b0) begin
            tests_failed++;
            $display("FAIL tenure_release1: gnt=%h exp=%b expected 00 0", gnt, expired);
        end
        tick();
        tests_run++;
        if (gnt !== 8'h20 || gnt_id !== 3'd5) begin
            tests_failed++;
            $display("FAIL tenure_regain5: gnt=%h id=%0d expected 20 5", gnt, gnt_id);
        end
        req = 8'h00;
        tick();
        tick();
    endtask

    task automatic test_simultaneous();
        do_reset();
        req = 8'h08;
        for (int c = 0; c < 4; c++) begin
            tick();
            tests_run++;
            if (gnt !== 8'h08 || expired !== 1'b0) begin
                tests_failed++;
                $display("FAIL simul_grant3 c%0d: gnt=%h exp=%b expected 08 0", c, gnt, expired);
            end
        end
        req = 8'h00;
        tick();
        tests_run++;
        if (gnt !== 8'h00 || expired !== 1'b0) begin
            tests_failed++;
            $display("FAIL simul_normal_release: gnt=%h exp=%b expected 00 0", gnt, expired);
        end
        tick();
        tests_run++;
        if (expired !== 1'b0 || gnt !== 8'h00) begin
            tests_failed++;
            $display("FAIL simul_no_pulse: gnt=%h exp=%b expected 00 0", gnt, expired);
        end
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        // Move ptr away from 0 so the post-reset check shows it was cleared.
        req = 8'h04;
        tick();
        req = 8'h00;
        tick();
        tick();
        req = 8'h40;
        tick();
        tests_run++;
        if (gnt !== 8'h40 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL midreset_grant6: gnt=%h busy=%b expected 40 1", gnt, busy);
        end
        #2;
        reset_n = 1'b0;
        #1;
        tests_run++;
        if (gnt !== 8'h00 || busy !== 1'b0 || gnt_id !== 3'd0) begin
            tests_failed++;
            $display("FAIL midreset_async: gnt=%h busy=%b id=%0d expected 00 0 0", gnt, busy, gnt_id);
        end
        req = 8'h41;
        tick();
        #3;
        reset_n = 1'b1;
        tick();
        tests_run++;
        if (gnt !== 8'h01 || gnt_id !== 3'd0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL midreset_ptr0: gnt=%h id=%0d busy=%b expected 01 0 1", gnt, gnt_id, busy);
        end
        req = 8'h00;
        tick();
        tick();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset_n      = 1'b0;
        req          = 8'h00;
        test_reset();
        test_basic();
        test_round_robin();
        test_wrap();
        test_tenure();
        test_simultaneous();
        test_reset_mid_grant();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
